cla_carry_seq: RTL and testbench

//  Multi-cycle carry-lookahead stage between the PG unit and the sum unit.

---
 rtl/cla_carry_seq.sv | 138 +++++++++++++
 tb/tb_cla_carry_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_carry_seq.sv
// Multi-cycle carry-lookahead stage: resolves GROUP carries per clock from latched p/g/cin.
// Latency: out_valid rises WIDTH/GROUP clock edges after the accept edge.
// Backpressure: results hold in DONE until out_ready; a new operand may be accepted on the release edge.
module cla_carry_seq #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] carry,
    output logic             cout,
    output logic             all_p,
    output logic             pg_conflict
);

    localparam int NGRP = WIDTH / GROUP;
    localparam int IW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A partial last group would leave carries unresolved, so refuse to build.
    generate
        if ((WIDTH % GROUP) != 0) begin : g_cfg_err
            $error("cla_carry_seq: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic [IW-1:0]    idx;
    logic             c_q;

    logic             accept;
    logic             last_grp;
    int               base;
    logic [WIDTH-1:0] p_sh;
    logic [WIDTH-1:0] g_sh;
    logic [GROUP-1:0] gp;
    logic [GROUP-1:0] gg;
    logic [GROUP:0]   cg_vec;
    logic             acc;
    logic             prod;
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] carry_nxt;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last_grp  = (idx == IW'(NGRP - 1));

    // Flat lookahead over the current group: each carry is a sum of products of p/g and the held carry.
    always_comb begin
        base   = int'(idx) * GROUP;
        p_sh   = p_q >> base;
        g_sh   = g_q >> base;
        gp     = p_sh[GROUP-1:0];
        gg     = g_sh[GROUP-1:0];
        cg_vec = '0;
        acc    = 1'b0;
        prod   = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            acc  = gg[k];
            prod = gp[k];
            for (int m = k - 1; m >= 0; m--) begin
                acc  = acc | (prod & gg[m]);
                prod = prod & gp[m];
            end
            acc          = acc | (prod & c_q);
            cg_vec[k+1]  = acc;
        end
    end

    // Merge the group's carries into bits base+1 .. base+GROUP; the top one falls off on the last group.
    always_comb begin
        ins       = WIDTH'(cg_vec) << base;
        msk       = WIDTH'({{GROUP{1'b1}}, 1'b0}) << base;
        carry_nxt = (carry & ~msk) | ins;
    end

    // Control FSM and result registers; reset discards any in-flight operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            p_q         <= '0;
            g_q         <= '0;
            idx         <= '0;
            c_q         <= 1'b0;
            carry       <= '0;
            cout        <= 1'b0;
            all_p       <= 1'b0;
            pg_conflict <= 1'b0;
        end else if (accept) begin
            state       <= S_RUN;
            p_q         <= p_in;
            g_q         <= g_in;
            idx         <= '0;
            c_q         <= cin;
            carry       <= {{(WIDTH-1){1'b0}}, cin};
            cout        <= 1'b0;
            all_p       <= &p_in;
            pg_conflict <= |(p_in & g_in);
        end else begin
            case (state)
                S_RUN: begin
                    carry <= carry_nxt;
                    c_q   <= cg_vec[GROUP];
                    if (last_grp) begin
                        cout  <= cg_vec[GROUP];
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_carry_seq.sv
// Directed bench for cla_carry_seq with a ripple-carry reference model and result scoreboard.
// Checks reset, latency, stall hold, back-to-back accept, async reset mid-run and pg_conflict.
// Inputs are driven away from the rising edge; outputs are sampled 1 time unit after it.
module tb_cla_carry_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] p_in = '0;
    logic [W-1:0] g_in = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] carry;
    logic         cout;
    logic         all_p;
    logic         pg_conflict;

    typedef struct packed {
        logic [W-1:0] carry;
        logic         cout;
        logic         all_p;
        logic         pg;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    exp_t         snap;
    logic [W-1:0] snap_carry;

    always #5 clk = ~clk;

    cla_carry_seq #(.WIDTH(W), .GROUP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .p_in       (p_in),
        .g_in       (g_in),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .carry      (carry),
        .cout       (cout),
        .all_p      (all_p),
        .pg_conflict(pg_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial ripple reference.
    function automatic exp_t model(input logic [W-1:0] p, input logic [W-1:0] g, input logic ci);
        exp_t r;
        logic c;
        c = ci;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r.carry[i] = c;
            c = g[i] | (p[i] & c);
        end
        r.cout  = c;
        r.all_p = &p;
        r.pg    = |(p & g);
        return r;
    endfunction

    // Present an operand, wait for in_ready, and return 1 unit after the accept edge.
    task automatic start(input logic [W-1:0] p, input logic [W-1:0] g, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        p_in = p;
        g_in = g;
        cin = ci;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        sb.push_back(model(p, g, ci));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid appears.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_carry"}, carry, e.carry);
            chk({tag, "_cout"}, cout, e.cout);
            chk({tag, "_all_p"}, all_p, e.all_p);
            chk({tag, "_pg_conflict"}, pg_conflict, e.pg);
        end
    endtask

    task automatic finish_handshake(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_idle"}, in_ready, 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_carry", carry, 0);
        chk("rst_cout", cout, 0);
        chk("rst_all_p", all_p, 0);
        chk("rst_pg", pg_conflict, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // 0xFFFF + 1
        start(16'hFFFE, 16'h0001, 1'b0);
        wait_done("t1");
        chk("t1_carry_lit", carry, 16'hFFFE);
        check_result("t1");
        finish_handshake("t1");

        // Full-width ripple
        start(16'hFFFF, 16'h0000, 1'b1);
        wait_done("t2");
        chk("t2_carry_lit", carry, 16'hFFFF);
        check_result("t2");
        finish_handshake("t2");

        // cin only, then a carry crossing a group boundary
        start(16'h0000, 16'h0000, 1'b1);
        wait_done("t3a");
        chk("t3a_carry_lit", carry, 16'h0001);
        check_result("t3a");
        finish_handshake("t3a");
        start(16'h00F0, 16'h0008, 1'b0);
        wait_done("t3b");
        chk("t3b_carry_lit", carry, 16'h01F0);
        check_result("t3b");
        finish_handshake("t3b");

        // Stall in DONE, then release together with a new operand
        out_ready = 1'b0;
        start(16'h0F0F, 16'h1010, 1'b0);
        wait_done("t4a");
        snap_carry = carry;
        snap = '{carry: carry, cout: cout, all_p: all_p, pg: pg_conflict};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_carry", carry, snap_carry);
            chk("t4_hold_cout", cout, snap.cout);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b1;
        p_in = 16'h00FF;
        g_in = 16'h0100;
        cin = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t4_release_in_ready", in_ready, 1);
        check_result("t4a");
        sb.push_back(model(16'h00FF, 16'h0100, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4_run_out_valid", out_valid, 0);
        chk("t4_run_in_ready", in_ready, 0);
        wait_done("t4b");
        check_result("t4b");
        finish_handshake("t4b");

        // Async reset during the second RUN cycle
        start(16'hFFFF, 16'h0000, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_carry", carry, 0);
        chk("t5_rst_cout", cout, 0);
        chk("t5_rst_all_p", all_p, 0);
        chk("t5_rst_pg", pg_conflict, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready", in_ready, 1);
        start(16'h0AAA, 16'h5000, 1'b1);
        wait_done("t5");
        check_result("t5");
        finish_handshake("t5");

        // pg_conflict set, then cleared by a clean operand
        start(16'h0010, 16'h0010, 1'b0);
        wait_done("t6a");
        chk("t6a_pg_lit", pg_conflict, 1);
        check_result("t6a");
        finish_handshake("t6a");
        start(16'h0011, 16'h0100, 1'b1);
        wait_done("t6b");
        chk("t6b_pg_lit", pg_conflict, 0);
        check_result("t6b");
        finish_handshake("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
